// File: rtl/wb_spix_pkg.sv
// Shared definitions for the wb_spix Wishbone SPI master: FSM state codes,
// CTRL field positions, register addresses and small shift helpers.
package wb_spix_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  localparam int CTRL_SIZE    = 4;   // two-bit field [5:4], holds byte count minus one
  localparam int CTRL_CPOL    = 6;
  localparam int CTRL_CPHA    = 7;
  localparam int CTRL_LSB     = 8;
  localparam int CTRL_AUTO_CS = 9;
  localparam int CTRL_MAN_CS  = 10;
  localparam int CTRL_IRQ_EN  = 11;
  localparam int CTRL_CS_SEL  = 12;  // three-bit field [14:12]
  localparam int CTRL_BUSY    = 31;

  localparam logic ADR_DATA = 1'b0;
  localparam logic ADR_CTRL = 1'b1;

  // Moves the top byte of an 8*(size+1)-bit word up to bit 31 for MSB-first shifting.
  function automatic logic [31:0] msb_align(input logic [31:0] d, input logic [1:0] size);
    return d << (5'd24 - {size, 3'b000});
  endfunction

  // Returns {outgoing bit, remaining shift register}.
  function automatic logic [32:0] shift_out(input logic [31:0] sr, input logic lsb);
    return lsb ? {sr[0], 1'b0, sr[31:1]} : {sr[31], sr[30:0], 1'b0};
  endfunction

endpackage

// File: rtl/spix_presc.sv
// Half-bit prescaler: tick_o pulses every 8*presc_i+1 cycles; load_i restarts the period.
module spix_presc #(
  parameter int PRESC_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_in,
  input  logic               load_i,
  input  logic [PRESC_W-1:0] presc_i,
  output logic               tick_o
);

  logic [PRESC_W+2:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == '0);
  assign cnt_d  = (load_i || tick_o) ? {presc_i, 3'b000} : cnt_q - (PRESC_W+3)'(1);

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/wb_spix.sv
// Wishbone SPI master: 1..4 byte transfers, CPOL/CPHA, LSB/MSB order, CS_CNT chip selects.
// Optional transfer-done interrupt is built when WB_SPIX_IRQ_EN is defined.
module wb_spix
  import wb_spix_pkg::*;
#(
  parameter int CS_CNT  = 2,
  parameter int PRESC_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_in,
  input  logic              wb_spi_cyc_i,
  input  logic              wb_spi_stb_i,
  input  logic              wb_spi_we_i,
  input  logic              wb_spi_adr_i,
  input  logic [31:0]       wb_spi_dat_i,
  output logic [31:0]       wb_spi_dat_o,
  output logic              wb_spi_ack_o,
  output logic [CS_CNT-1:0] spi_cs_o,
  output logic              spi_sck_o,
  output logic              spi_sdo_o,
  input  logic              spi_sdi_i,
  output logic              irq_o
);

`ifdef WB_SPIX_IRQ_EN
  localparam logic [31:0] IRQ_MASK = 32'h0000_0800;
`else
  localparam logic [31:0] IRQ_MASK = 32'h0000_0000;
`endif
  localparam logic [31:0] CTRL_WMASK = 32'((64'd1 << PRESC_W) - 64'd1) | 32'h0000_77F0 | IRQ_MASK;

  logic [1:0]  state_q, state_d;
  logic [31:0] ctrl_q, ctrl_d, tx_q, tx_d, rx_q, rx_d;
  logic        sdo_q, sdo_d, ph_q, ph_d;
  logic [5:0]  edge_q, edge_d;
  logic        tick, busy, wr_data, wr_ctrl, rd_data;
  logic [31:0] tx_al;

  logic [1:0] size;
  logic [2:0] cs_sel;
  logic       cpol, cpha, lsb, auto_cs, man_cs;

  assign size    = ctrl_q[CTRL_SIZE +: 2];
  assign cs_sel  = ctrl_q[CTRL_CS_SEL +: 3];
  assign cpol    = ctrl_q[CTRL_CPOL];
  assign cpha    = ctrl_q[CTRL_CPHA];
  assign lsb     = ctrl_q[CTRL_LSB];
  assign auto_cs = ctrl_q[CTRL_AUTO_CS];
  assign man_cs  = ctrl_q[CTRL_MAN_CS];

  assign busy = (state_q != ST_IDLE);

  // Only DATA writes stall while busy; an acked DATA write therefore always starts a transfer.
  assign wb_spi_ack_o = wb_spi_cyc_i & wb_spi_stb_i
                      & ~(wb_spi_we_i & (wb_spi_adr_i == ADR_DATA) & busy);
  assign wr_data = wb_spi_ack_o &  wb_spi_we_i & (wb_spi_adr_i == ADR_DATA);
  assign wr_ctrl = wb_spi_ack_o &  wb_spi_we_i & (wb_spi_adr_i == ADR_CTRL) & ~busy;
  assign rd_data = wb_spi_ack_o & ~wb_spi_we_i & (wb_spi_adr_i == ADR_DATA);

  assign wb_spi_dat_o = (wb_spi_adr_i == ADR_CTRL) ? (ctrl_q | {busy, 31'b0}) : rx_q;
  assign tx_al        = lsb ? wb_spi_dat_i : msb_align(wb_spi_dat_i, size);

  spix_presc #(.PRESC_W(PRESC_W)) u_presc (
    .clk_i  (clk_i),
    .rst_in (rst_in),
    .load_i (wr_data),
    .presc_i(ctrl_q[PRESC_W-1:0]),
    .tick_o (tick)
  );

  always_comb begin
    // NOTE: every next-state variable gets a default first so no path can infer a latch.
    state_d = state_q;
    ctrl_d  = ctrl_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    sdo_d   = sdo_q;
    ph_d    = ph_q;
    edge_d  = edge_q;
    if (wr_ctrl) ctrl_d = wb_spi_dat_i & CTRL_WMASK;
    case (state_q)
      ST_IDLE: if (wr_data) begin
        state_d = ST_SETUP;
        rx_d    = '0;
        ph_d    = 1'b0;
        edge_d  = '0;
        if (cpha) tx_d = tx_al;
        else      {sdo_d, tx_d} = shift_out(tx_al, lsb);
      end
      ST_SETUP: if (tick) state_d = ST_XFER;
      ST_XFER: if (tick) begin
        ph_d   = ~ph_q;
        edge_d = edge_q + 6'd1;
        // edge_q[0]==0 is an odd (1st, 3rd, ...) edge; CPHA picks which parity samples.
        if (edge_q[0] == cpha) begin
          if (lsb) rx_d = (rx_q >> 1) | (32'(spi_sdi_i) << {size, 3'b111});
          else     rx_d = {rx_q[30:0], spi_sdi_i};
        end else begin
          {sdo_d, tx_d} = shift_out(tx_q, lsb);
        end
        if (edge_q == {size, 4'hF}) state_d = ST_HOLD;
      end
      default: if (tick) state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= ST_IDLE;
      ctrl_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      sdo_q   <= 1'b0;
      ph_q    <= 1'b0;
      edge_q  <= '0;
    end else begin
      // NOTE: state updates use <= so every flop sees pre-edge values regardless of order.
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      sdo_q   <= sdo_d;
      ph_q    <= ph_d;
      edge_q  <= edge_d;
    end
  end

  assign spi_sck_o = cpol ^ ph_q;
  assign spi_sdo_o = sdo_q;

  always_comb begin
    spi_cs_o = '1;
    if ((auto_cs && busy) || man_cs)
      for (int i = 0; i < CS_CNT; i++)
        if (cs_sel == 3'(i)) spi_cs_o[i] = 1'b0;
  end

`ifdef WB_SPIX_IRQ_EN
  logic irq_q, irq_d;

  // A DATA read in the completion cycle wins; a DATA write cannot coincide with completion.
  always_comb begin
    irq_d = irq_q;
    if (rd_data)                            irq_d = 1'b0;
    else if ((state_q == ST_HOLD) && tick)  irq_d = 1'b1;
    else if (wr_data)                       irq_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) irq_q <= 1'b0;
    else         irq_q <= irq_d;
  end

  assign irq_o = irq_q & ctrl_q[CTRL_IRQ_EN];
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_spix.sv
// Directed self-checking bench for wb_spix with a result scoreboard and an SPI slave/monitor.
module tb_wb_spix;
  import wb_spix_pkg::*;

  localparam int CS_CNT = 2;
`ifdef WB_SPIX_IRQ_EN
  localparam logic [31:0] IRQ_BIT = 32'h0000_0800;
  localparam logic        IRQ_ON  = 1'b1;
`else
  localparam logic [31:0] IRQ_BIT = 32'h0000_0000;
  localparam logic        IRQ_ON  = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0, adr = 1'b0;
  logic [31:0] dat_w = '0, dat_r;
  logic        ack, sck, sdo, sdi, irq;
  logic [CS_CNT-1:0] cs;

  logic        loop_en = 1'b0, slave_en = 1'b0, mon_en = 1'b0;
  logic        slave_sdi = 1'b0;
  logic [31:0] slave_word = 32'hCAFE_BABE;
  int          slave_idx = 0;

  int n_checks = 0;
  int n_pass   = 0;
  int cs_low[CS_CNT];
  int rise_cnt = 0;
  int bit_rd   = 0;
  logic        got_bits[$];
  logic        exp_bits[$];
  logic [31:0] exp_rx[$];

  assign sdi = loop_en ? sdo : slave_sdi;

  wb_spix #(.CS_CNT(CS_CNT), .PRESC_W(4)) dut (
    .clk_i       (clk),
    .rst_in      (rst_n),
    .wb_spi_cyc_i(cyc),
    .wb_spi_stb_i(stb),
    .wb_spi_we_i (we),
    .wb_spi_adr_i(adr),
    .wb_spi_dat_i(dat_w),
    .wb_spi_dat_o(dat_r),
    .wb_spi_ack_o(ack),
    .spi_cs_o    (cs),
    .spi_sck_o   (sck),
    .spi_sdo_o   (sdo),
    .spi_sdi_i   (sdi),
    .irq_o       (irq)
  );

  initial for (int i = 0; i < CS_CNT; i++) cs_low[i] = 0;
  always @(negedge clk) for (int i = 0; i < CS_CNT; i++) if (!cs[i]) cs_low[i]++;
  always @(posedge sck) if (mon_en) begin rise_cnt++; got_bits.push_back(sdo); end
  always @(negedge sck) if (slave_en && slave_idx < 32) begin
    slave_sdi = slave_word[slave_idx];
    slave_idx++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  task automatic wb_write(input logic a, input logic [31:0] d, output int stall);
    stall = 0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; dat_w = d;
    #1;
    while (!ack && stall < 5000) begin @(negedge clk); #1; stall++; end
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_read(input logic a, output logic [31:0] d);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
    #1;
    d = dat_r;
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    logic [31:0] d;
    int n = 0;
    do begin wb_read(ADR_CTRL, d); n++; end while (d[CTRL_BUSY] && n < 5000);
    check(tag, 32'(d[CTRL_BUSY]), 32'd0);
  endtask

  task automatic xfer(input logic [31:0] tx, input logic [31:0] rx_exp);
    int st;
    exp_rx.push_back(rx_exp);
    wb_write(ADR_DATA, tx, st);
    check("xfer_ack", st, 0);
  endtask

  task automatic check_rx(input string tag);
    logic [31:0] d;
    wb_read(ADR_DATA, d);
    check(tag, d, exp_rx.pop_front());
  endtask

  task automatic check_bits(input string tag);
    check({tag, "_cnt"}, 32'(got_bits.size() - bit_rd), 32'(exp_bits.size()));
    foreach (exp_bits[k])
      if (bit_rd + k < got_bits.size()) check(tag, 32'(got_bits[bit_rd + k]), 32'(exp_bits[k]));
    bit_rd = got_bits.size();
    exp_bits.delete();
  endtask

  initial begin
    logic [31:0] d;
    int st, base0, base1, rbase;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_cs", 32'(cs), 32'(2'b11));
    check("rst_sck", 32'(sck), 32'd0);
    check("rst_sdo", 32'(sdo), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    rst_n = 1'b1;
    wb_read(ADR_CTRL, d); check("rst_ctrl", d, 32'd0);
    wb_read(ADR_DATA, d); check("rst_data", d, 32'd0);

    // 1: mode 0, MSB, 1 byte, presc 0, auto_cs, loopback
    loop_en = 1'b1;
    wb_write(ADR_CTRL, 32'h0000_0200 | IRQ_BIT, st);
    mon_en = 1'b1;
    base0 = cs_low[0]; rbase = rise_cnt;
    for (int i = 7; i >= 0; i--) exp_bits.push_back(1'((32'hA5 >> i) & 1));
    xfer(32'h0000_00A5, 32'h0000_00A5);
    wait_idle("t1_idle");
    mon_en = 1'b0;
    check_bits("t1_sdo");
    check("t1_rise", rise_cnt - rbase, 8);
    check("t1_cs0_low", cs_low[0] - base0, 18);
    check("t1_irq_set", 32'(irq), 32'(IRQ_ON));
    check_rx("t1_rx");
    check("t1_irq_clr", 32'(irq), 32'd0);

    // 2: mode 3, LSB, 4 bytes, presc 1, slave returns 0xCAFEBABE
    loop_en = 1'b0;
    wb_write(ADR_CTRL, 32'h0000_03F1, st);
    check("t2_sck_idle_pre", 32'(sck), 32'd1);
    slave_en = 1'b1; mon_en = 1'b1;
    rbase = rise_cnt;
    for (int i = 0; i < 32; i++) exp_bits.push_back(1'((32'h1234_5678 >> i) & 1));
    xfer(32'h1234_5678, 32'hCAFE_BABE);
    wait_idle("t2_idle");
    mon_en = 1'b0; slave_en = 1'b0;
    check("t2_sck_idle_post", 32'(sck), 32'd1);
    check("t2_rise", rise_cnt - rbase, 32);
    check_bits("t2_sdo");
    check_rx("t2_rx");

    // 3: second DATA write 2 cycles after the first stalls until IDLE (18 busy cycles)
    loop_en = 1'b1;
    wb_write(ADR_CTRL, 32'h0000_0200, st);
    wb_write(ADR_DATA, 32'h0000_0011, st);
    repeat (2) @(posedge clk);
    exp_rx.push_back(32'h0000_0066);
    wb_write(ADR_DATA, 32'h0000_0066, st);
    check("t3_stall", st, 16);
    wb_read(ADR_CTRL, d);
    check("t3_busy2", 32'(d[CTRL_BUSY]), 32'd1);
    wait_idle("t3_idle");
    check_rx("t3_rx");

    // 4: CTRL write while busy is acked but ignored
    xfer(32'h0000_0077, 32'h0000_0077);
    wb_write(ADR_CTRL, 32'h0000_0203, st);
    check("t4_ctrl_ack", st, 0);
    wb_read(ADR_CTRL, d);
    check("t4_ctrl_busy", d, 32'h8000_0200);
    wait_idle("t4_idle");
    wb_read(ADR_CTRL, d);
    check("t4_ctrl_kept", d, 32'h0000_0200);
    wb_write(ADR_CTRL, 32'h0000_0203, st);
    wb_read(ADR_CTRL, d);
    check("t4_ctrl_new", d, 32'h0000_0203);
    check_rx("t4_rx");

    // 5: cs_sel 1 then out-of-range cs_sel 5
    wb_write(ADR_CTRL, 32'h0000_1200, st);
    base0 = cs_low[0]; base1 = cs_low[1];
    xfer(32'h0000_003C, 32'h0000_003C);
    wait_idle("t5a_idle");
    check("t5a_cs0", cs_low[0] - base0, 0);
    check("t5a_cs1", cs_low[1] - base1, 18);
    check_rx("t5a_rx");
    wb_write(ADR_CTRL, 32'h0000_5200, st);
    base0 = cs_low[0]; base1 = cs_low[1];
    xfer(32'h0000_00C3, 32'h0000_00C3);
    wait_idle("t5b_idle");
    check("t5b_cs0", cs_low[0] - base0, 0);
    check("t5b_cs1", cs_low[1] - base1, 0);
    check_rx("t5b_rx");

    // 6: reset in the middle of a slow 4-byte transfer
    wb_write(ADR_CTRL, 32'h0000_0232, st);
    xfer(32'hDEAD_BEEF, 32'h0000_0000);
    repeat (60) @(posedge clk);
    #1;
    check("t6_cs_mid", 32'(cs), 32'(2'b10));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t6_cs_rst", 32'(cs), 32'(2'b11));
    check("t6_sck_rst", 32'(sck), 32'd0);
    @(posedge clk);
    #1;
    check("t6_sdo_rst", 32'(sdo), 32'd0);
    check("t6_irq_rst", 32'(irq), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wb_read(ADR_CTRL, d);
    check("t6_ctrl", d, 32'd0);
    check_rx("t6_rx");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
